uart_status_framer: RTL and testbench

Packetizer sitting directly upstream of uart_send. On each report request (the 1 s tick) it snapshots the current time, temperature and alarm flags and sends them as a fixed 7-byte frame. Each byte is handed to uart_send through the uart_en / uart_din / uart_tx_busy handshake. It replaces the single-byte temperature/0xFF reporting in top with a framed, checksummed status record.

---
 rtl/uart_status_framer.sv | 143 ++++++++++++++
 tb/tb_uart_status_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_status_framer
// Purpose  : Snapshots time/temperature/alarm status and sends it to uart_send
//            as a 7-byte checksummed frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_status_framer #(
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       report_req,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] temp,
  input  logic       alarm_active,
  input  logic       temp_alarm,
  input  logic       uart_tx_busy,
  output logic       uart_en,
  output logic [7:0] uart_din,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] c_timeout  = 8'(BUSY_TIMEOUT);
  localparam logic [2:0] c_last_idx = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT_H = 3'd2,
    WAIT_L = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_hour;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic [7:0] r_temp;
  logic [7:0] r_flags;
  logic [7:0] r_sum;
  logic [7:0] r_tcnt;
  logic [2:0] r_idx;
  logic [7:0] w_byte;

  // Byte 6 is the running sum of everything already strobed out.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0:    w_byte = HEADER;
      3'd1:    w_byte = r_hour;
      3'd2:    w_byte = r_min;
      3'd3:    w_byte = r_sec;
      3'd4:    w_byte = r_temp;
      3'd5:    w_byte = r_flags;
      3'd6:    w_byte = r_sum;
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_hour     <= 8'h00;
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
      r_temp     <= 8'h00;
      r_flags    <= 8'h00;
      r_sum      <= 8'h00;
      r_tcnt     <= 8'h00;
      r_idx      <= 3'd0;
      uart_en    <= 1'b0;
      uart_din   <= 8'h00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      uart_en    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (report_req && (r_state != IDLE) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;

      case (r_state)
        IDLE: begin
          if (report_req) begin
            r_hour  <= hour;
            r_min   <= min;
            r_sec   <= sec;
            r_temp  <= temp;
            r_flags <= {6'b0, temp_alarm, alarm_active};
            r_sum   <= 8'h00;
            r_idx   <= 3'd0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!uart_tx_busy) begin
            uart_en  <= 1'b1;
            uart_din <= w_byte;
            r_sum    <= r_sum + w_byte;
            r_tcnt   <= 8'h00;
            r_state  <= WAIT_H;
          end
        end
        WAIT_H: begin
          if (uart_tx_busy) begin
            r_state <= WAIT_L;
          end else if (r_tcnt + 8'd1 == c_timeout) begin
            frame_err <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        WAIT_L: begin
          if (!uart_tx_busy) begin
            if (r_idx == c_last_idx) begin
              frame_done <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ISSUE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign frame_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_status_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_status_framer
// Purpose  : Directed, table-driven bench for uart_status_framer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_status_framer;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       report_req;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic [7:0] temp;
  logic       alarm_active;
  logic       temp_alarm;
  logic       uart_tx_busy;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       frame_busy;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] drop_cnt;

  uart_status_framer #(.HEADER(8'hAA), .BUSY_TIMEOUT(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .report_req   (report_req),
    .hour         (hour),
    .min          (min),
    .sec          (sec),
    .temp         (temp),
    .alarm_active (alarm_active),
    .temp_alarm   (temp_alarm),
    .uart_tx_busy (uart_tx_busy),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .drop_cnt     (drop_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // uart_send stand-in: busy rises 3 cycles after a strobe and stays high 20 cycles.
  logic model_en;
  logic force_hi;
  int   bcnt;
  always @(negedge sys_clk) begin
    if (!sys_rst_n)                  bcnt <= 0;
    else if (uart_en && model_en)    bcnt <= 1;
    else if (bcnt > 0 && bcnt < 23)  bcnt <= bcnt + 1;
    else                             bcnt <= 0;
  end
  assign uart_tx_busy = force_hi | ((bcnt >= 3) && (bcnt <= 22));

  logic [7:0] strobes[$];
  int cyc = 0, n_done = 0, n_err = 0, n_both = 0, last_en_cyc = 0, last_err_cyc = 0;
  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (uart_en) begin
      strobes.push_back(uart_din);
      last_en_cyc <= cyc + 1;
    end
    if (frame_done) n_done <= n_done + 1;
    if (frame_err) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc + 1;
    end
    if (frame_done && frame_err) n_both <= n_both + 1;
  end

  typedef struct {
    logic [7:0]  hour;
    logic [7:0]  min;
    logic [7:0]  sec;
    logic [7:0]  temp;
    logic        aa;
    logic        ta;
    logic [55:0] exp;
  } vec_t;
  vec_t vecs[4];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_req();
    tick();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic set_inputs(input vec_t v);
    hour = v.hour; min = v.min; sec = v.sec; temp = v.temp;
    alarm_active = v.aa; temp_alarm = v.ta;
  endtask

  task automatic wait_end(input int bd, input int be, input int limit, output bit to);
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (n_done > bd || n_err > be) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [55:0] exp);
    logic [55:0] e;
    logic [8:0]  act;
    e = exp;
    check({tag, "_nbytes"}, strobes.size() - base, 7);
    for (int i = 0; i < 7; i++) begin
      act = (base + i < strobes.size()) ? {1'b0, strobes[base + i]} : 9'h1FF;
      check($sformatf("%s_byte%0d", tag, i), act, {1'b0, e[55 - 8*i -: 8]});
    end
  endtask

  // Runs a complete frame with the current inputs and checks every byte.
  task automatic run_frame(input string tag, input logic [55:0] exp);
    int base, bd, be;
    bit to;
    base = strobes.size(); bd = n_done; be = n_err;
    pulse_req();
    wait_end(bd, be, 1000, to);
    check({tag, "_timeout"}, to, 0);
    tick();
    check_frame(tag, base, exp);
    check({tag, "_done"}, n_done - bd, 1);
    check({tag, "_err"}, n_err - be, 0);
    check({tag, "_busy_after"}, frame_busy, 0);
  endtask

  initial begin
    int base, bd, be, rel;
    bit to, hit;

    vecs[0] = '{8'h0C, 8'h22, 8'h38, 8'h1B, 1'b1, 1'b0, 56'hAA0C22381B012C};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 56'hAA0000000000AA};
    vecs[2] = '{8'h17, 8'h3B, 8'h3B, 8'hFF, 1'b1, 1'b1, 56'hAA173B3BFF0339};
    vecs[3] = '{8'h01, 8'h02, 8'h03, 8'h80, 1'b0, 1'b1, 56'hAA010203800232};

    sys_rst_n = 1'b0; report_req = 1'b0; model_en = 1'b1; force_hi = 1'b0;
    set_inputs(vecs[0]);
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    check("rst_uart_en", uart_en, 0);
    check("rst_uart_din", uart_din, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    for (int v = 0; v < 4; v++) begin
      set_inputs(vecs[v]);
      run_frame($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Inputs change after the snapshot; the frame must not move.
    set_inputs(vecs[0]);
    base = strobes.size(); bd = n_done; be = n_err;
    pulse_req();
    for (int i = 0; i < 200 && (strobes.size() - base) < 2; i++) tick();
    hour = 8'h05; temp = 8'h30;
    wait_end(bd, be, 1000, to);
    check("snap_timeout", to, 0);
    check_frame("snap", base, vecs[0].exp);

    reset_dut();
    set_inputs(vecs[0]);
    base = strobes.size(); bd = n_done; be = n_err;
    pulse_req();
    for (int k = 0; k < 3; k++) begin
      repeat (30) tick();
      pulse_req();
    end
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (frame_done) begin
        report_req = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    tick();
    report_req = 1'b0;
    repeat (10) tick();
    check("drop_done_seen", hit, 1);
    check("drop_cnt4", drop_cnt, 4);
    check("drop_nframes", n_done - bd, 1);
    check("drop_nbytes", strobes.size() - base, 7);
    check("drop_busy_after", frame_busy, 0);

    reset_dut();
    force_hi = 1'b1;
    pulse_req();
    for (int k = 0; k < 254; k++) pulse_req();
    check("drop_cnt254", drop_cnt, 254);
    for (int k = 0; k < 46; k++) pulse_req();
    check("drop_sat255", drop_cnt, 255);
    reset_dut();
    force_hi = 1'b0;
    tick();

    model_en = 1'b0;
    base = strobes.size(); bd = n_done; be = n_err;
    pulse_req();
    wait_end(bd, be, 200, to);
    tick();
    check("to_timeout", to, 0);
    check("to_nstrobes", strobes.size() - base, 1);
    check("to_first", (strobes.size() > base) ? strobes[base] : 8'h00, 8'hAA);
    check("to_err", n_err - be, 1);
    check("to_done", n_done - bd, 0);
    check("to_latency", last_err_cyc - last_en_cyc, 16);
    check("to_idle", frame_busy, 0);
    model_en = 1'b1;
    run_frame("to_retry", vecs[0].exp);

    force_hi = 1'b1;
    base = strobes.size(); bd = n_done; be = n_err;
    tick();
    pulse_req();
    repeat (48) tick();
    check("bs_no_strobe", strobes.size() - base, 0);
    check("bs_busy_wait", frame_busy, 1);
    force_hi = 1'b0;
    rel = cyc;
    wait_end(bd, be, 1000, to);
    check("bs_timeout", to, 0);
    check("bs_strobe_delay", (strobes.size() > base) ? 0 : 1, 0);
    tick();
    check_frame("bs", base, vecs[0].exp);

    // Asynchronous reset while byte 3 is on the wire.
    base = strobes.size();
    pulse_req();
    for (int i = 0; i < 400 && (strobes.size() - base) < 4; i++) tick();
    check("rm_reached_b3", strobes.size() - base, 4);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rm_uart_en", uart_en, 0);
    check("rm_uart_din", uart_din, 0);
    check("rm_frame_busy", frame_busy, 0);
    check("rm_frame_done", frame_done, 0);
    check("rm_frame_err", frame_err, 0);
    check("rm_drop_cnt", drop_cnt, 0);
    tick();
    sys_rst_n = 1'b1;
    base = strobes.size();
    repeat (60) tick();
    check("rm_quiet", strobes.size() - base, 0);
    check("rm_idle", frame_busy, 0);
    run_frame("rm_new", vecs[0].exp);

    check("done_err_overlap", n_both, 0);
    check("bs_release_cyc", last_en_cyc > rel ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
